// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word per frame and shifts it out as
// an 8N1-style UART frame (start bit, DATA_W data bits LSB first, stop bit).
module fifo_uart_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_en_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_en_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (tx_en_i && !fifo_empty_i) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_data_i;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = (tx_en_i && !fifo_empty_i) ? S_POP : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    tx_d    = 1'b1;
    rd_en_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = 1'b0;
    case (state_d)
      S_POP:   rd_en_d = 1'b1;
      S_START: tx_d    = 1'b0;
      S_DATA:  tx_d    = shift_d[0];
      S_STOP:  done_d  = (cnt_d == CNT_MAX);
      default: tx_d    = 1'b1;
    endcase
  end

  assign fifo_rd_en_o = rd_en_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule
